// File: rtl/vote_frame_receiver_pkg.sv
// Shared constants and types for the vote frame receiver: framing bytes,
// parser states and the buffered vote entry.
package vote_pkg;

   localparam logic [7:0] VOTE_START_BYTE = 8'hA5;
   localparam logic [7:0] VOTE_CHK_XOR    = 8'h5A;

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_GET_ID   = 2'd1,
      ST_GET_CAND = 2'd2,
      ST_GET_CHK  = 2'd3
   } parser_state_t;

   typedef struct packed {
      logic [7:0] id;
      logic       cand;
   } vote_entry_t;

   function automatic logic [7:0] vote_checksum(input logic [7:0] id, input logic [7:0] cand);
      return id ^ cand ^ VOTE_CHK_XOR;
   endfunction

endpackage

// File: rtl/vote_frame_receiver_if.sv
// Byte-stream input, release handshake and statistics of the vote frame receiver.
// The receiver connects through the slave modport; its driver uses master.
interface vote_frame_receiver_if #(
   parameter int FIFO_DEPTH = 8
) ();
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             valid_in;
   logic [7:0]       byte_in;
   logic             request_new_vote;
   logic             vote_out;
   logic [7:0]       voter_id_out;
   logic             valid_vote_out;
   logic [7:0]       accepted_count;
   logic [7:0]       rejected_count;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      output valid_in, byte_in, request_new_vote,
      input  vote_out, voter_id_out, valid_vote_out,
      input  accepted_count, rejected_count, fifo_count
   );

   modport slave (
      input  valid_in, byte_in, request_new_vote,
      output vote_out, voter_id_out, valid_vote_out,
      output accepted_count, rejected_count, fifo_count
   );
endinterface

// File: rtl/vote_frame_receiver_fifo.sv
// Synchronous FIFO of vote entries; the head is captured into a register on pop
// and held there until the next pop.
module vote_fifo
   import vote_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       push,
   input  vote_entry_t                push_data,
   input  logic                       pop,
   output vote_entry_t                rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   vote_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   vote_entry_t      rd_data_q, rd_data_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop    = pop && (count_q != '0);
      do_push   = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d  = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      rd_data_d = do_pop ? mem[rd_ptr_q] : rd_data_q;
   end

   // Storage has no reset so it can map onto block RAM.
   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
endmodule

// File: rtl/vote_frame_receiver.sv
// Frames UART bytes into checked votes, buffers them and releases one per request.
// Optional duplicate-ID rejection is enabled by defining VOTE_DUP_FILTER_EN.
module vote_frame_receiver
   import vote_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   vote_frame_receiver_if.slave bus
);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   parser_state_t    state_q, state_d;
   logic [7:0]       id_q, id_d;
   logic [7:0]       cand_q, cand_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic             pending_q, pending_d;
   logic [7:0]       acc_q, acc_d;
   logic [7:0]       rej_q, rej_d;
   logic             valid_vote_q, valid_vote_d;

   logic             frame_done, idle_timeout, accept, reject;
   logic             chk_good, cand_good, has_space, dup_id;
   logic             pop, fifo_full, fifo_empty;
   vote_entry_t      push_entry, rd_entry;
   logic [CNT_W-1:0] fifo_count;

`ifdef VOTE_DUP_FILTER_EN
   logic [255:0]     seen_q, seen_d;
`endif

   vote_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (accept),
      .push_data (push_entry),
      .pop       (pop),
      .rd_data   (rd_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Parser state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= ST_HUNT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.valid_in) begin
         unique case (state_q)
            ST_HUNT:     if (bus.byte_in == VOTE_START_BYTE) state_d = ST_GET_ID;
            ST_GET_ID:   state_d = ST_GET_CAND;
            ST_GET_CAND: state_d = ST_GET_CHK;
            ST_GET_CHK:  state_d = ST_HUNT;
            default:     state_d = ST_HUNT;
         endcase
      end else if (idle_timeout) begin
         state_d = ST_HUNT;
      end
   end

   // Frame verdict decoded from the parser state and the current byte.
   always_comb begin
      pop          = (bus.request_new_vote || pending_q) && !fifo_empty;
      idle_timeout = (state_q != ST_HUNT) && !bus.valid_in && (idle_q == IDLE_LAST);
      frame_done   = bus.valid_in && (state_q == ST_GET_CHK);
      chk_good     = (bus.byte_in == vote_checksum(id_q, cand_q));
      cand_good    = (cand_q[7:1] == 7'd0);
      has_space    = !fifo_full || pop;
`ifdef VOTE_DUP_FILTER_EN
      dup_id       = seen_q[id_q];
`else
      dup_id       = 1'b0;
`endif
      accept       = frame_done && chk_good && cand_good && has_space && !dup_id;
      reject       = (frame_done && !accept) || idle_timeout;
      push_entry   = '{id: id_q, cand: cand_q[0]};
   end

   always_comb begin
      id_d         = id_q;
      cand_d       = cand_q;
      if (bus.valid_in && state_q == ST_GET_ID)   id_d   = bus.byte_in;
      if (bus.valid_in && state_q == ST_GET_CAND) cand_d = bus.byte_in;

      if (bus.valid_in || state_q == ST_HUNT || idle_timeout) idle_d = '0;
      else                                                    idle_d = idle_q + IDLE_W'(1);

      // A request that cannot be served now is remembered exactly once.
      if (pop)                        pending_d = 1'b0;
      else if (bus.request_new_vote)  pending_d = 1'b1;
      else                            pending_d = pending_q;

      valid_vote_d = pop;
      acc_d        = (accept && acc_q != 8'hFF) ? acc_q + 8'd1 : acc_q;
      rej_d        = (reject && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
`ifdef VOTE_DUP_FILTER_EN
      seen_d       = seen_q;
      if (accept) seen_d[id_q] = 1'b1;
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         id_q         <= '0;
         cand_q       <= '0;
         idle_q       <= '0;
         pending_q    <= 1'b0;
         acc_q        <= '0;
         rej_q        <= '0;
         valid_vote_q <= 1'b0;
`ifdef VOTE_DUP_FILTER_EN
         seen_q       <= '0;
`endif
      end else begin
         id_q         <= id_d;
         cand_q       <= cand_d;
         idle_q       <= idle_d;
         pending_q    <= pending_d;
         acc_q        <= acc_d;
         rej_q        <= rej_d;
         valid_vote_q <= valid_vote_d;
`ifdef VOTE_DUP_FILTER_EN
         seen_q       <= seen_d;
`endif
      end
   end

   assign bus.vote_out       = rd_entry.cand;
   assign bus.voter_id_out   = rd_entry.id;
   assign bus.valid_vote_out = valid_vote_q;
   assign bus.accepted_count = acc_q;
   assign bus.rejected_count = rej_q;
   assign bus.fifo_count     = fifo_count;
endmodule

// File: tb/tb_vote_frame_receiver.sv
// Directed bench for vote_frame_receiver with a queue-based reference model
// compared every cycle, plus literal expectations from the test plan.
module tb_vote_frame_receiver;
   localparam int DEPTH = 8;
   localparam int TMO   = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vote_frame_receiver_if #(.FIFO_DEPTH(DEPTH)) bus ();

   vote_frame_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int id; int cand; } ent_t;
   ent_t q[$];
   int  m_nbytes = 0, m_id = 0, m_cand = 0, m_idle = 0, m_pend = 0;
   int  m_acc = 0, m_rej = 0, m_vout = 0, m_idout = 0, m_vvalid = 0;
   bit  seen [256];

   task automatic model_reset();
      q.delete();
      m_nbytes = 0; m_id = 0; m_cand = 0; m_idle = 0; m_pend = 0;
      m_acc = 0; m_rej = 0; m_vout = 0; m_idout = 0; m_vvalid = 0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
   endtask

   task automatic model_step();
      int   b, req, vin;
      bit   pop, push, ok;
      ent_t e;
      vin  = int'(bus.valid_in);
      b    = int'(bus.byte_in);
      req  = int'(bus.request_new_vote);
      pop  = (req != 0 || m_pend != 0) && q.size() > 0;
      push = 1'b0;
      if (vin != 0) begin
         m_idle = 0;
         if (m_nbytes == 0) begin
            if (b == 'hA5) m_nbytes = 1;
         end else if (m_nbytes == 1) begin
            m_id = b; m_nbytes = 2;
         end else if (m_nbytes == 2) begin
            m_cand = b; m_nbytes = 3;
         end else begin
            ok = (b == (m_id ^ m_cand ^ 'h5A)) && (m_cand < 2) && (q.size() < DEPTH || pop);
`ifdef VOTE_DUP_FILTER_EN
            ok = ok && !seen[m_id];
`endif
            if (ok) push = 1'b1;
            else if (m_rej < 255) m_rej++;
            m_nbytes = 0;
         end
      end else if (m_nbytes != 0) begin
         m_idle++;
         if (m_idle == TMO) begin
            if (m_rej < 255) m_rej++;
            m_nbytes = 0;
            m_idle = 0;
         end
      end
      m_vvalid = pop ? 1 : 0;
      if (pop) begin
         e = q.pop_front();
         m_vout = e.cand; m_idout = e.id; m_pend = 0;
      end else if (req != 0) begin
         m_pend = 1;
      end
      if (push) begin
         e.id = m_id; e.cand = m_cand;
         q.push_back(e);
         seen[m_id] = 1'b1;
         if (m_acc < 255) m_acc++;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("valid_vote_out", int'(bus.valid_vote_out), m_vvalid);
         check("vote_out", int'(bus.vote_out), m_vout);
         check("voter_id_out", int'(bus.voter_id_out), m_idout);
         check("accepted_count", int'(bus.accepted_count), m_acc);
         check("rejected_count", int'(bus.rejected_count), m_rej);
         check("fifo_count", int'(bus.fifo_count), q.size());
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit req = 1'b0);
      bus.valid_in = 1'b1;
      bus.byte_in = b;
      bus.request_new_vote = req;
      tick();
      bus.valid_in = 1'b0;
      bus.request_new_vote = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] id, input logic [7:0] cand,
                             input logic [7:0] chk, input bit req_on_chk = 1'b0);
      send_byte(8'hA5);
      send_byte(id);
      send_byte(cand);
      send_byte(chk, req_on_chk);
   endtask

   task automatic pulse_req();
      bus.request_new_vote = 1'b1;
      tick();
      bus.request_new_vote = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      tick();
   endtask

   logic [7:0] drain_ids [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h29};
   logic [7:0] id8, c8;

   initial begin
      bus.valid_in = 1'b0;
      bus.byte_in = 8'h00;
      bus.request_new_vote = 1'b0;
      idle(3);
      check("reset_fifo_count", int'(bus.fifo_count), 0);
      check("reset_valid", int'(bus.valid_vote_out), 0);
      check("reset_id", int'(bus.voter_id_out), 0);
      rst_n = 1'b1;
      tick();

      // Good frame then a request.
      send_frame(8'h07, 8'h01, 8'h5C);
      check("t1_accepted", int'(bus.accepted_count), 1);
      pulse_req();
      check("t1_valid", int'(bus.valid_vote_out), 1);
      check("t1_vote", int'(bus.vote_out), 1);
      check("t1_id", int'(bus.voter_id_out), 8'h07);
      tick();
      check("t1_strobe_one_cycle", int'(bus.valid_vote_out), 0);
      check("t1_id_held", int'(bus.voter_id_out), 8'h07);

      // Request before data: release two cycles after the CHK strobe.
      do_reset();
      pulse_req();
      idle(3);
      send_frame(8'h10, 8'h00, 8'h4A);
      check("t2_valid_t1", int'(bus.valid_vote_out), 0);
      tick();
      check("t2_valid_t2", int'(bus.valid_vote_out), 1);
      check("t2_id", int'(bus.voter_id_out), 8'h10);
      check("t2_vote", int'(bus.vote_out), 0);

      // Bad checksum, bad candidate, then good frames (one with 0xA5 as ID).
      do_reset();
      send_frame(8'h07, 8'h01, 8'h00);
      send_frame(8'h08, 8'h02, 8'h50);
      check("t3_rejected", int'(bus.rejected_count), 2);
      check("t3_fifo", int'(bus.fifo_count), 0);
      send_frame(8'h09, 8'h00, 8'h53);
      send_frame(8'hA5, 8'h01, 8'hFE);
      check("t3_accepted", int'(bus.accepted_count), 2);

      // Gap just short of the timeout keeps the frame alive.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h07);
      idle(TMO - 1);
      send_byte(8'h01);
      send_byte(8'h5C);
      check("t4_short_gap_acc", int'(bus.accepted_count), 1);
      check("t4_short_gap_rej", int'(bus.rejected_count), 0);

      // Timeout abandons the partial frame.
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h07);
      idle(TMO + 1);
      check("t4_timeout_rej", int'(bus.rejected_count), 1);
      send_frame(8'h07, 8'h01, 8'h5C);
      check("t4_after_acc", int'(bus.accepted_count), 1);
      pulse_req();
      check("t4_after_id", int'(bus.voter_id_out), 8'h07);
      check("t4_after_vote", int'(bus.vote_out), 1);

      // Overflow, push+pop while full, drain order, push+request while empty.
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         id8 = 8'(8'h20 + i);
         c8  = 8'(i & 1);
         send_frame(id8, c8, id8 ^ c8 ^ 8'h5A);
      end
      check("t5_full_count", int'(bus.fifo_count), DEPTH);
      check("t5_full_rej", int'(bus.rejected_count), 1);
      check("t5_full_acc", int'(bus.accepted_count), DEPTH);
      send_frame(8'h29, 8'h01, 8'h29 ^ 8'h01 ^ 8'h5A, 1'b1);
      check("t5_pushpop_count", int'(bus.fifo_count), DEPTH);
      check("t5_pushpop_acc", int'(bus.accepted_count), DEPTH + 1);
      check("t5_pushpop_id", int'(bus.voter_id_out), 8'h20);
      for (int i = 0; i < DEPTH; i++) begin
         pulse_req();
         check("t5_drain_id", int'(bus.voter_id_out), int'(drain_ids[i]));
      end
      check("t5_empty", int'(bus.fifo_count), 0);
      send_frame(8'h30, 8'h00, 8'h6A, 1'b1);
      check("t5_empty_pushreq_t1", int'(bus.valid_vote_out), 0);
      tick();
      check("t5_empty_pushreq_t2", int'(bus.valid_vote_out), 1);
      check("t5_empty_pushreq_id", int'(bus.voter_id_out), 8'h30);

      // Asynchronous reset mid-frame.
      do_reset();
      send_frame(8'h07, 8'h01, 8'h5C);
      send_byte(8'hA5);
      send_byte(8'h11);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_fifo", int'(bus.fifo_count), 0);
      check("t6_async_acc", int'(bus.accepted_count), 0);
      tick();
      rst_n = 1'b1;
      tick();
      send_byte(8'h01);
      send_byte(8'h5C);
      check("t6_partial_dropped", int'(bus.accepted_count), 0);
      send_frame(8'h11, 8'h00, 8'h4B);
      check("t6_after_acc", int'(bus.accepted_count), 1);

      // Rejection counter saturates.
      do_reset();
      repeat (260) send_frame(8'h08, 8'h02, 8'h50);
      check("t7_rej_saturate", int'(bus.rejected_count), 255);

      // Duplicate IDs.
      do_reset();
      send_frame(8'h07, 8'h01, 8'h5C);
      send_frame(8'h07, 8'h01, 8'h5C);
`ifdef VOTE_DUP_FILTER_EN
      check("t8_dup_acc", int'(bus.accepted_count), 1);
      check("t8_dup_rej", int'(bus.rejected_count), 1);
`else
      check("t8_dup_acc", int'(bus.accepted_count), 2);
      check("t8_dup_rej", int'(bus.rejected_count), 0);
`endif

      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
